// File: rtl/wave_play_ctrl_pkg.sv
// Purpose: shared constants, FSM encodings and the address-width helper for wave_play_ctrl.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package wave_play_ctrl_pkg;

  localparam int ADDR_W = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1, never less than one bit.
  function automatic int clogb2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/wave_play_ctrl_rate_tick.sv
// Purpose: programmable sample-rate divider; tick every div+1 enabled clocks.
// Latency: combinational tick from the registered count; first tick div cycles after load.
// Backpressure: none; counting pauses while en is low, load restarts from zero.
module wave_play_ctrl_rate_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  // Tick on equality with the latched period; reload clears the count.
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    tick  = en && (cnt_q == div_q);
    if (load) begin
      div_d = div;
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= '0;
      cnt_q <= '0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wave_play_ctrl.sv
// Purpose: waveform playback sequencer (address generator, one-shot/loop); optional REPEAT_EN adds repeat_cnt.
// Latency: first address step div+1 cycles after the accepted start; strobes registered with the address.
// Backpressure: none; start ignored while busy, stop aborts to IDLE on the next cycle.
module wave_play_ctrl
  import wave_play_ctrl_pkg::*;
#(
  parameter int N     = 32,
  parameter int DIV_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              oneshot,
  input  logic [DIV_W-1:0]  div,
`ifdef REPEAT_EN
  input  logic [7:0]        repeat_cnt,
`endif
  output logic [ADDR_W-1:0] address,
  output logic              smp_stb,
  output logic              wrap,
  output logic              busy,
  output logic              done
);

  localparam int S = clogb2(N);
  localparam logic [S-1:0] ADDR_END = S'(N - 1);
  localparam logic [S-1:0] ADDR_PEN = S'(N - 2);

  state_t         state_q, state_d;
  logic [S-1:0]   addr_q, addr_d;
  logic           oneshot_q, oneshot_d;
  logic           smp_q, smp_d;
  logic           wrap_q, wrap_d;
  logic           done_q, done_d;
  logic           load;
  logic           tick;
  logic           final_period;
`ifdef REPEAT_EN
  logic [7:0]     rpt_q, rpt_d;
  assign final_period = (rpt_q == 8'd0);
`else
  assign final_period = 1'b1;
`endif

  wave_play_ctrl_rate_tick #(.DIV_W(DIV_W)) u_rate_tick (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .en   (busy && !stop),
    .div  (div),
    .tick (tick)
  );

  // Next-state, address stepping and strobe generation.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    oneshot_d = oneshot_q;
    smp_d     = 1'b0;
    wrap_d    = 1'b0;
    done_d    = 1'b0;
    load      = 1'b0;
`ifdef REPEAT_EN
    rpt_d     = rpt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        addr_d = '0;
        if (start && !stop) begin
          load      = 1'b1;
          oneshot_d = oneshot;
`ifdef REPEAT_EN
          rpt_d     = repeat_cnt;
`endif
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          addr_d  = '0;
          state_d = ST_IDLE;
        end else if (tick) begin
          smp_d = 1'b1;
          // One-shot enters LAST on reaching the final address of its final period.
          if (oneshot_q && final_period && addr_q == ADDR_PEN) begin
            addr_d  = addr_q + S'(1);
            state_d = ST_LAST;
          end else if (addr_q == ADDR_END) begin
            addr_d = '0;
            wrap_d = 1'b1;
`ifdef REPEAT_EN
            if (rpt_q != 8'd0) rpt_d = rpt_q - 8'd1;
`endif
          end else begin
            addr_d = addr_q + S'(1);
          end
        end
      end
      ST_LAST: begin
        if (stop) begin
          addr_d  = '0;
          state_d = ST_IDLE;
        end else if (tick) begin
          addr_d  = '0;
          smp_d   = 1'b1;
          wrap_d  = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        addr_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      oneshot_q <= 1'b0;
      smp_q     <= 1'b0;
      wrap_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef REPEAT_EN
      rpt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      oneshot_q <= oneshot_d;
      smp_q     <= smp_d;
      wrap_q    <= wrap_d;
      done_q    <= done_d;
`ifdef REPEAT_EN
      rpt_q     <= rpt_d;
`endif
    end
  end

  assign address = ADDR_W'(addr_q);
  assign smp_stb = smp_q;
  assign wrap    = wrap_q;
  assign done    = done_q;
  assign busy    = (state_q == ST_RUN) || (state_q == ST_LAST);

endmodule

// File: tb/tb_wave_play_ctrl.sv
// Purpose: randomized check of wave_play_ctrl (N=5 and N=2 instances) against an elapsed-time model.
// Latency: model predicts outputs one clock after each sampled input set.
// Backpressure: n/a.
module tb_wave_play_ctrl;

  localparam int DIV_W = 16;
  localparam int NI    = 2;

  logic             clk = 1'b0;
  logic             rst, start, stop, oneshot;
  logic [DIV_W-1:0] div;
  logic [7:0]       repeat_cnt;
  logic [11:0]      address [NI];
  logic             smp_stb [NI];
  logic             wrap    [NI];
  logic             busy    [NI];
  logic             done    [NI];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wave_play_ctrl #(.N(5), .DIV_W(DIV_W)) u_dut5 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot), .div(div),
`ifdef REPEAT_EN
    .repeat_cnt(repeat_cnt),
`endif
    .address(address[0]), .smp_stb(smp_stb[0]), .wrap(wrap[0]), .busy(busy[0]), .done(done[0])
  );

  wave_play_ctrl #(.N(2), .DIV_W(DIV_W)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .oneshot(oneshot), .div(div),
`ifdef REPEAT_EN
    .repeat_cnt(repeat_cnt),
`endif
    .address(address[1]), .smp_stb(smp_stb[1]), .wrap(wrap[1]), .busy(busy[1]), .done(done[1])
  );

  // Reference model: outputs derived from cycles elapsed since the accepted start.
  int m_n     [NI] = '{5, 2};
  int m_act   [NI];
  int m_t     [NI];
  int m_per   [NI];
  int m_os    [NI];
  int m_total [NI];
  int e_addr  [NI];
  int e_stb   [NI];
  int e_wrap  [NI];
  int e_busy  [NI];
  int e_done  [NI];

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_step(input int i);
    int s;
    e_addr[i] = 0; e_stb[i] = 0; e_wrap[i] = 0; e_done[i] = 0;
    if (rst) begin
      m_act[i] = 0;
    end else if (m_act[i] == 0) begin
      if (start && !stop) begin
        m_act[i] = 1;
        m_t[i]   = 0;
        m_per[i] = int'(div) + 1;
        m_os[i]  = int'(oneshot);
`ifdef REPEAT_EN
        m_total[i] = m_n[i] * (int'(repeat_cnt) + 1);
`else
        m_total[i] = m_n[i];
`endif
      end
    end else if (stop) begin
      m_act[i] = 0;
    end else begin
      m_t[i]++;
      s         = m_t[i] / m_per[i];
      e_stb[i]  = (m_t[i] % m_per[i] == 0) ? 1 : 0;
      e_addr[i] = s % m_n[i];
      e_wrap[i] = (e_stb[i] == 1 && e_addr[i] == 0) ? 1 : 0;
      if (m_os[i] == 1 && s == m_total[i]) begin
        e_done[i] = 1;
        e_addr[i] = 0;
        m_act[i]  = 0;
      end
    end
    e_busy[i] = m_act[i];
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("addr%0d", i), int'(address[i]), e_addr[i]);
      chk($sformatf("stb%0d",  i), int'(smp_stb[i]), e_stb[i]);
      chk($sformatf("wrap%0d", i), int'(wrap[i]),    e_wrap[i]);
      chk($sformatf("busy%0d", i), int'(busy[i]),    e_busy[i]);
      chk($sformatf("done%0d", i), int'(done[i]),    e_done[i]);
    end
  endtask

  task automatic go(input int os, input int d, input int rc);
    start = 1'b1; oneshot = os[0]; div = DIV_W'(d); repeat_cnt = rc[7:0];
    cycle();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; oneshot = 1'b0; div = '0; repeat_cnt = 8'd0;
    for (int i = 0; i < NI; i++) m_act[i] = 0;
    repeat (3) cycle();
    rst = 1'b0;
    cycle();

    // One-shot at full rate, then the idle tail.
    go(1, 0, 0);
    repeat (14) cycle();
    // Looping playback at one sample every three clocks.
    go(0, 2, 0);
    repeat (35) cycle();
    // Start with a new rate while busy must be ignored.
    go(1, 7, 1);
    repeat (20) cycle();
    // Abort mid-run.
    stop = 1'b1; cycle(); stop = 1'b0;
    repeat (3) cycle();
    // Simultaneous start and stop in idle.
    start = 1'b1; stop = 1'b1; cycle(); start = 1'b0; stop = 1'b0;
    repeat (3) cycle();
    // Reset near the end of a one-shot, then a fresh playback.
    go(1, 1, 0);
    repeat (8) cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    go(1, 0, 2);
    repeat (20) cycle();

    // Randomized traffic.
    for (int k = 0; k < 6000; k++) begin
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 399) == 0);
      oneshot    = $urandom_range(0, 1) == 1;
      div        = ($urandom_range(0, 9) == 0) ? DIV_W'(7) : DIV_W'($urandom_range(0, 3));
      repeat_cnt = 8'($urandom_range(0, 3));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
